// File: rtl/dmem_responder.sv
// dmem_responder: target side of the Memory-stage load/store port.
// It takes one word-aligned request at a time over valid/ready. It waits
// WAIT_CYCLES cycles, accesses the internal word array, and then returns a
// one-cycle response pulse.
// Build option: define DMEM_ERR_EN to flag misaligned and out-of-range
// accesses on resp_err. Without it, resp_err is tied to 0 and addresses wrap
// modulo the array size.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  // Request captured at accept; the requester may drop its inputs afterwards.
  logic        hold_we;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_be;

  logic [31:0] mem [DEPTH_WORDS];

  // Operands of the array access that happens at the coming edge, if any.
  logic             accept;
  logic             acc_fire;
  logic             acc_we;
  logic             acc_err;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic [IDX_W-1:0] acc_idx;

  assign req_ready = (state == IDLE) || (state == RESP);
  assign accept    = req_valid && req_ready;
  assign busy      = (state == WAIT) || ((state == RESP) && !accept);

  // Zero wait: the access uses the live request at its accept edge.
  // Otherwise it uses the held request when the wait count expires.
  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_fire  = accept;
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_fire  = (state == WAIT) && (wait_cnt == 4'd0);
      acc_we    = hold_we;
      acc_addr  = hold_addr;
      acc_wdata = hold_wdata;
      acc_be    = hold_be;
    end
  end

  assign acc_idx = acc_addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(4 * DEPTH_WORDS));
`else
  assign acc_err = 1'b0;
`endif

  // Some address bits are ignored, and in the zero-wait build the holding
  // registers are dead. They are collected here deliberately.
  logic unused_bits;
  assign unused_bits = ^{hold_we, hold_addr, hold_wdata, hold_be, wait_cnt, acc_addr};

  // Control FSM, request capture and the registered response.
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // updates from pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            hold_we    <= req_we;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
            hold_be    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (acc_fire) begin
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        resp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Byte-lane store into the array. A faulting store or a reset edge writes
  // nothing.
  // NOTE: the array is deliberately not reset. Clearing it would need a write
  // port per word. Its contents are undefined until stored.
  always_ff @(posedge clk) begin
    if (!rst && acc_fire && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Two instances run side by side: a 1024-word array with a 2-cycle wait, and
// a 16-word array with no wait.
// A transaction-level model predicts ready, busy, the response pulse, the
// load data and the fault flag on every cycle.
// Directed sequences pin the model with literal expectations. A randomized
// phase then exercises holding, back-to-back traffic and resets at random
// points.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int N = 2;

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 1024 : 16;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic [3:0]  req_be     [N];
  logic        resp_valid [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];
  logic        busy       [N];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_slow (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // edge_no counts rising edges. "Cycle k" is the interval after edge k.
  // A request accepted at edge E is accessed at edge E+wait and answered in
  // that same cycle.
  int unsigned edge_no = 0;
  bit          started = 1'b0;
  bit          pend     [N];
  int unsigned acc_at   [N];
  bit          t_we     [N];
  logic [31:0] t_addr   [N];
  logic [31:0] t_wdata  [N];
  logic [3:0]  t_be     [N];
  logic [31:0] exp_rdata [N];
  logic [31:0] exp_mask  [N];
  bit          exp_err   [N];
  logic [31:0] ref_mem   [N][1024];
  bit   [3:0]  ref_known [N][1024];

  function automatic bit is_fault(input int i, input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return ((a % 32'd4) != 32'd0) || (a >= 32'(4 * depth_of(i)));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_access(input int i);
    int unsigned idx;
    idx = int'((t_addr[i] >> 2) % 32'(depth_of(i)));
    exp_err[i]   = is_fault(i, t_addr[i]);
    exp_rdata[i] = 32'd0;
    exp_mask[i]  = 32'hFFFF_FFFF;
    if (!exp_err[i]) begin
      if (t_we[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (t_be[i][b]) begin
            ref_mem[i][idx][8*b +: 8] = t_wdata[i][8*b +: 8];
            ref_known[i][idx][b] = 1'b1;
          end
        end
      end else begin
        exp_rdata[i] = ref_mem[i][idx];
        for (int b = 0; b < 4; b++) exp_mask[i][8*b +: 8] = {8{ref_known[i][idx][b]}};
      end
    end
  endtask

  always @(posedge clk) begin
    int unsigned ne;
    bit rdy, acc;
    ne = edge_no + 1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        pend[i] = 1'b0;
      end else begin
        rdy = !pend[i] || (edge_no == acc_at[i]);
        acc = req_valid[i] && rdy;
        if (pend[i] && edge_no == acc_at[i]) pend[i] = 1'b0;
        if (acc) begin
          pend[i]    = 1'b1;
          t_we[i]    = req_we[i];
          t_addr[i]  = req_addr[i];
          t_wdata[i] = req_wdata[i];
          t_be[i]    = req_be[i];
          acc_at[i]  = ne + 32'(wait_of(i));
        end
        if (pend[i] && acc_at[i] == ne) model_access(i);
      end
    end
    if (rst) started = 1'b1;
    edge_no = ne;
  end

  // Compare process: every output, every cycle, mid-cycle.
  always @(negedge clk) begin
    bit ev, erdy, ebusy;
    if (started) begin
      for (int i = 0; i < N; i++) begin
        ev    = pend[i] && (edge_no == acc_at[i]);
        erdy  = !pend[i] || ev;
        ebusy = pend[i] && !(ev && req_valid[i]);
        check($sformatf("u%0d req_ready", i), 32'(req_ready[i]), 32'(erdy));
        check($sformatf("u%0d resp_valid", i), 32'(resp_valid[i]), 32'(ev));
        check($sformatf("u%0d busy", i), 32'(busy[i]), 32'(ebusy));
        if (ev) begin
          check($sformatf("u%0d resp_err", i), 32'(resp_err[i]), 32'(exp_err[i]));
          if (exp_mask[i] != 32'd0)
            check($sformatf("u%0d resp_rdata", i), resp_rdata[i] & exp_mask[i],
                  exp_rdata[i] & exp_mask[i]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int i, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr;
    req_wdata[i] = wdata; req_be[i] = be;
    @(negedge clk);
    while (!req_ready[i] && n < 64) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d accepted within bound", i), 32'(req_ready[i]), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0; req_addr[i] = $urandom(); req_wdata[i] = $urandom();
  endtask

  task automatic collect(input int i, output logic [31:0] rd, output logic er, output int lat);
    bit got;
    got = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
    while (!got && lat < 64) begin
      @(negedge clk);
      lat++;
      if (resp_valid[i]) begin
        got = 1'b1; rd = resp_rdata[i]; er = resp_err[i];
      end
    end
    check($sformatf("u%0d response within bound", i), 32'(got), 32'd1);
  endtask

  task automatic xact(input int i, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rd, output logic er, output int lat);
    issue(i, we, addr, wdata, be);
    collect(i, rd, er, lat);
  endtask

  function automatic logic [31:0] rand_addr(input int i);
    int unsigned d, r, span, idx;
    d    = 32'(depth_of(i));
    span = (d > 32) ? 32 : d;
    r    = $urandom_range(0, 19);
    idx  = $urandom_range(0, span - 1);
    if (r < 14)      return 32'(idx * 4);
    else if (r < 17) return 32'(idx * 4 + $urandom_range(1, 3));
    else if (r < 19) return 32'(4 * d + $urandom_range(0, 63) * 4);
    else             return $urandom();
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] b2b [4];

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'd0;
      req_wdata[i] = 32'd0; req_be[i] = 4'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d reset ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("u%0d reset valid", i), 32'(resp_valid[i]), 32'd0);
      check($sformatf("u%0d reset busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d reset rdata", i), resp_rdata[i], 32'd0);
      check($sformatf("u%0d reset err", i), 32'(resp_err[i]), 32'd0);
    end

    // Store then load with a 2-cycle wait.
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("store latency", 32'(lat), 32'd3);
    check("store err", 32'(er), 32'd0);
    check("store rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h10, 32'd0, 4'd0, rd, er, lat);
    check("load latency", 32'(lat), 32'd3);
    check("load rdata", rd, 32'hDEAD_BEEF);

    // Byte enables.
    xact(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lat);
    xact(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    xact(0, 1'b0, 32'h20, 32'd0, 4'd0, rd, er, lat);
    check("byte-enable merge", rd, 32'h11BB_33DD);

    // No-op store: acked but changes nothing.
    xact(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    check("be=0 store ack latency", 32'(lat), 32'd3);
    xact(0, 1'b0, 32'h20, 32'd0, 4'd0, rd, er, lat);
    check("be=0 store no-op", rd, 32'h11BB_33DD);

    // Faults, or aliasing when fault detection is compiled out.
    xact(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    xact(0, 1'b0, 32'h13, 32'd0, 4'd0, rd, er, lat);
`ifdef DMEM_ERR_EN
    check("misaligned load err", 32'(er), 32'd1);
    check("misaligned load rdata", rd, 32'd0);
`else
    check("misaligned load err", 32'(er), 32'd0);
    check("misaligned load rdata", rd, 32'hDEAD_BEEF);
`endif
    xact(0, 1'b1, 32'h1000, 32'h0BAD_CAFE, 4'hF, rd, er, lat);
    xact(0, 1'b0, 32'h0, 32'd0, 4'd0, rd, er, lat);
`ifdef DMEM_ERR_EN
    check("word 0 after faulting store", rd, 32'hCAFE_F00D);
`else
    check("word 0 after aliased store", rd, 32'h0BAD_CAFE);
`endif

    // Back-to-back loads on the zero-wait instance.
    for (int j = 0; j < 4; j++) begin
      b2b[j] = 32'h0100_0000 * 32'(j + 1) + 32'(j);
      xact(1, 1'b1, 32'(4 * j), b2b[j], 4'hF, rd, er, lat);
    end
    check("zero-wait latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'd0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j < 4) check($sformatf("b2b ready %0d", j), 32'(req_ready[1]), 32'd1);
      if (j > 0) begin
        check($sformatf("b2b valid %0d", j - 1), 32'(resp_valid[1]), 32'd1);
        check($sformatf("b2b rdata %0d", j - 1), resp_rdata[1], b2b[j-1]);
      end
      if (j < 4) begin
        @(posedge clk); #1;
        if (j < 3) req_addr[1] = 32'(4 * (j + 1));
        else req_valid[1] = 1'b0;
      end
    end

    // Reset in WAIT abandons the store.
    xact(0, 1'b1, 32'h40, 32'h600D_F00D, 4'hF, rd, er, lat);
    issue(0, 1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("no response after reset", 32'(resp_valid[0]), 32'd0);
      check("ready after reset", 32'(req_ready[0]), 32'd1);
    end
    xact(0, 1'b0, 32'h40, 32'd0, 4'd0, rd, er, lat);
    check("abandoned store left prior data", rd, 32'h600D_F00D);

    // Request held during WAIT waits for RESP.
    xact(0, 1'b1, 32'h50, 32'h1234_5678, 4'hF, rd, er, lat);
    xact(0, 1'b1, 32'h54, 32'h9ABC_DEF0, 4'hF, rd, er, lat);
    issue(0, 1'b0, 32'h50, 32'd0, 4'd0);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h54;
    collect(0, rd, er, lat);
    check("first of held pair latency", 32'(lat), 32'd3);
    check("first of held pair data", rd, 32'h1234_5678);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    collect(0, rd, er, lat);
    check("second of held pair latency", 32'(lat), 32'd3);
    check("second of held pair data", rd, 32'h9ABC_DEF0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 6000; c++) begin
      bit held [N];
      @(negedge clk);
      for (int i = 0; i < N; i++) held[i] = req_valid[i] && !(req_ready[i] && !rst);
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < N; i++) begin
        if (!held[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_we[i]    = 1'($urandom_range(0, 1));
          req_addr[i]  = rand_addr(i);
          req_wdata[i] = $urandom();
          req_be[i]    = 4'($urandom_range(0, 15));
        end
      end
    end

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
